// File: rtl/branch_predict_eval.sv
// branch_predict_eval: branch condition resolver with a PC-indexed table of
// 2-bit saturating predictors. The lookup is combinational. The resolved
// outcome and the mispredict pulse are registered.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_eval #(
    parameter  int WordSize  = 32,
    parameter  int BhtDepth  = 64,
    localparam int IndexBits = $clog2(BhtDepth)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [WordSize-1:0] pred_pc,
    output logic                pred_taken,
    input  logic                res_valid,
    input  logic [WordSize-1:0] res_pc,
    input  logic [1:0]          res_branch_cond,
    input  logic [WordSize-1:0] res_alu_out,
    input  logic                res_pred_taken,
`ifdef BRANCH_STATS_EN
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts,
`endif
    output logic                branch_taken,
    output logic                mispredict
);

    logic [1:0]           bht [BhtDepth];
    logic [IndexBits-1:0] pred_idx, res_idx;
    logic                 taken, is_branch, do_update, mis_next;
    logic [1:0]           cur_ctr, new_ctr;

    // PC bits [1:0] are ignored, and the high bits alias. No tags are kept.
    assign pred_idx = pred_pc[IndexBits+1:2];
    assign res_idx  = res_pc[IndexBits+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[WordSize-1:IndexBits+2], pred_pc[1:0],
                              res_pc[WordSize-1:IndexBits+2], res_pc[1:0]};

    // The prediction sees the pre-update entry. A same-cycle write lands at the edge.
    assign pred_taken = bht[pred_idx][1];

    // Resolve the condition and build the next value of the saturating counter
    always_comb begin
        taken = 1'b0;
        unique case (res_branch_cond)
            2'd0: taken = 1'b0;
            2'd1: taken = |res_alu_out;
            2'd2: taken = ~|res_alu_out;
            2'd3: taken = 1'b1;
        endcase
        is_branch = res_valid & (res_branch_cond != 2'd0);
        // Unconditional jumps do not train the table. Only cond 1/2 update it.
        do_update = res_valid & (res_branch_cond == 2'd1 || res_branch_cond == 2'd2);
        mis_next  = is_branch & (taken != res_pred_taken);
        cur_ctr   = bht[res_idx];
        new_ctr   = cur_ctr;
        if (taken && cur_ctr != 2'b11)
            new_ctr = cur_ctr + 2'b01;
        else if (!taken && cur_ctr != 2'b00)
            new_ctr = cur_ctr - 2'b01;
    end

    // Registered outcome, mispredict pulse and predictor table
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            branch_taken <= 1'b0;
            mispredict   <= 1'b0;
            for (int i = 0; i < BhtDepth; i++)
                bht[i] <= 2'b01;
        end else begin
            branch_taken <= res_valid & taken;
            mispredict   <= mis_next;
            if (do_update)
                bht[res_idx] <= new_ctr;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating statistics counters. They never wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (is_branch && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (mis_next && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_eval.sv
// Directed testbench for branch_predict_eval. The expected values are worked out by hand.
module tb_branch_predict_eval;

    logic        clk, rstn;
    logic [31:0] pred_pc, res_pc, res_alu_out;
    logic        pred_taken, res_valid, res_pred_taken;
    logic [1:0]  res_branch_cond;
    logic        branch_taken, mispredict;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int checks = 0;
    int failures = 0;

    branch_predict_eval #(.WordSize(32), .BhtDepth(64)) dut (
        .clk(clk), .rstn(rstn),
        .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc),
        .res_branch_cond(res_branch_cond), .res_alu_out(res_alu_out),
        .res_pred_taken(res_pred_taken),
`ifdef BRANCH_STATS_EN
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
        .branch_taken(branch_taken), .mispredict(mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] c,
                         input logic [31:0] alu, input logic pt);
        res_valid = v; res_pc = pc; res_branch_cond = c;
        res_alu_out = alu; res_pred_taken = pt;
    endtask

    initial begin
        logic [7:0] bt_tab;
        bt_tab = 8'b1101_1000;  // index = cond*2 + (alu==5)

        // The design is held in reset while the inputs are random
        rstn = 1'b0;
        pred_pc = '0;
        drive(1'b0, '0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, 2'($urandom_range(3)), $urandom, 1'($urandom_range(1)));
            pred_pc = $urandom;
            tick();
            check("rst_bt", {31'd0, branch_taken}, 32'd0);
            check("rst_mis", {31'd0, mispredict}, 32'd0);
            check("rst_pred", {31'd0, pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
            check("rst_sb", stat_branches, 32'd0);
            check("rst_sm", stat_mispredicts, 32'd0);
`endif
        end
        rstn = 1'b1;

        // Resolution truth table on pc 0x20. That entry is unused elsewhere.
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < 2; a++) begin
                drive(1'b1, 32'h20, 2'(c), (a == 1) ? 32'h5 : 32'h0, 1'b0);
                tick();
                check($sformatf("tt_bt_c%0d_a%0d", c, a), {31'd0, branch_taken}, {31'd0, bt_tab[c*2+a]});
                check($sformatf("tt_mis_c%0d_a%0d", c, a), {31'd0, mispredict}, {31'd0, bt_tab[c*2+a]});
            end
        end
`ifdef BRANCH_STATS_EN
        check("tt_sb", stat_branches, 32'd6);
        check("tt_sm", stat_mispredicts, 32'd4);
`endif

        // Saturation at 0x100: 01 -> 10 -> 11 -> 11 -> 11
        pred_pc = 32'h100;
        drive(1'b1, 32'h100, 2'd1, 32'h1, 1'b0);
        #1 check("sat_pre", {31'd0, pred_taken}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sat_inc%0d", i), {31'd0, pred_taken}, 32'd1);
        end
        check("sat_mis", {31'd0, mispredict}, 32'd1);
        // Decrement: 11 -> 10 -> 01 -> 00 -> 00 -> 00
        drive(1'b1, 32'h100, 2'd1, 32'h0, 1'b0);
        tick(); check("sat_dec0", {31'd0, pred_taken}, 32'd1);
        check("sat_dec_mis", {31'd0, mispredict}, 32'd0);
        tick(); check("sat_dec1", {31'd0, pred_taken}, 32'd0);
        tick(); tick(); tick();
        check("sat_dec4", {31'd0, pred_taken}, 32'd0);
        // The entry must be 00, so one taken update only reaches 01
        drive(1'b1, 32'h100, 2'd2, 32'h0, 1'b1);
        tick(); check("sat_floor", {31'd0, pred_taken}, 32'd0);
        check("sat_floor_mis", {31'd0, mispredict}, 32'd0);

        // Lookup and update of entry 0x40 (01) in the same cycle
        drive(1'b1, 32'h40, 2'd1, 32'h7, 1'b0);
        pred_pc = 32'h40;
        #1 check("col_pre", {31'd0, pred_taken}, 32'd0);
        tick();
        drive(1'b0, '0, 2'd0, '0, 1'b0);
        check("col_post", {31'd0, pred_taken}, 32'd1);

        // Aliasing: pc 0 and pc 0x100 share index 0, which is 01 here
        pred_pc = 32'h100;
        drive(1'b1, 32'h0, 2'd1, 32'h1, 1'b1);
        tick(); tick();
        check("alias", {31'd0, pred_taken}, 32'd1);

        // Jumps and invalid slots must not train entry 0x80 (01)
        pred_pc = 32'h80;
        drive(1'b1, 32'h80, 2'd3, 32'h0, 1'b1);
        tick(); tick();
        check("jmp_noupd", {31'd0, pred_taken}, 32'd0);
        check("jmp_bt", {31'd0, branch_taken}, 32'd1);
        check("jmp_mis", {31'd0, mispredict}, 32'd0);
        drive(1'b0, 32'h80, 2'd1, 32'h1, 1'b0);
        tick(); tick();
        check("inv_noupd", {31'd0, pred_taken}, 32'd0);
        check("inv_bt", {31'd0, branch_taken}, 32'd0);
        check("inv_mis", {31'd0, mispredict}, 32'd0);

        // Async reset between edges while mispredict=1 and the entries are trained
        drive(1'b1, 32'h80, 2'd3, 32'h0, 1'b0);
        tick();
        check("ar_mis_before", {31'd0, mispredict}, 32'd1);
        drive(1'b0, '0, 2'd0, '0, 1'b0);
        pred_pc = 32'h100;
        #2 rstn = 1'b0;
        #1;
        check("ar_mis", {31'd0, mispredict}, 32'd0);
        check("ar_bt", {31'd0, branch_taken}, 32'd0);
        check("ar_pred100", {31'd0, pred_taken}, 32'd0);
        pred_pc = 32'h40;
        #1 check("ar_pred40", {31'd0, pred_taken}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("ar_sb", stat_branches, 32'd0);
`endif
        rstn = 1'b1;
        tick();
        check("ar_pred40_after", {31'd0, pred_taken}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
